// File: rtl/uart_tx_serializer.sv
// UART transmit serializer.
// Pops one word from a show-ahead TX FIFO and shifts it out LSB first as a
// start bit, 5..8 data bits, an optional parity bit and 1, 1.5 or 2 stop
// bits. Each bit lasts OVERSAMPLE baud_tick pulses (OVERSAMPLE: even, 8..32).
// Line control is captured at frame start, so lcr edits mid-frame only take
// effect on the next frame. The one exception is break (live lcr[6]), which
// forces the line low at any time without stalling the state machine.
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       PRESETn,
    input  logic       baud_tick,
    input  logic [7:0] lcr,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    input  logic       cts_en,
    input  logic       nCTS,
    output logic       TXD,
    output logic       tx_busy,
    output logic       tx_done
);

    // Bit lengths in baud ticks. 2*OVERSAMPLE can reach 64, hence 7 bits.
    localparam logic [6:0] BIT_TICKS    = 7'(OVERSAMPLE);
    localparam logic [6:0] STOP2_TICKS  = 7'(2 * OVERSAMPLE);
    localparam logic [6:0] STOP15_TICKS = 7'((3 * OVERSAMPLE) / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t     state_reg, state_next;
    logic [6:0] tick_cnt_reg, tick_cnt_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    // Captured lcr[5:0]: word length, extra stop, PEN, EPS, stick parity.
    logic [5:0] lcr_latched_reg, lcr_latched_next;
    // XOR of the data bits actually sent, captured at frame start.
    logic       data_xor_reg, data_xor_next;
    // Line level the FSM wants, before the break override.
    logic       line_reg, line_next;
    logic       txd_reg;

    logic       start_ok;
    logic       tick_last;
    logic       frame_end;
    logic       pop_now;
    logic       parity_bit;
    logic [6:0] stop_limit;
    logic [6:0] cur_limit;
    logic [2:0] last_bit_idx;
    logic [7:0] word_mask;

    // lcr[7] has no function in the transmitter.
    logic unused_lcr_msb;
    assign unused_lcr_msb = lcr[7];

    // Mask of the data bits that belong to the word length on the live lcr.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_word_mask
            assign word_mask[gi] = (4'(gi) < (4'd5 + {2'b00, lcr[1:0]}));
        end
    endgenerate

    // A frame may only begin from IDLE with data present and CTS permitting.
    assign start_ok = !fifo_empty && (!cts_en || !nCTS);

    // Stop length follows the captured line control.
    always_comb begin
        stop_limit = BIT_TICKS;
        if (lcr_latched_reg[2]) begin
            if (lcr_latched_reg[1:0] == 2'b00) begin
                stop_limit = STOP15_TICKS;
            end else begin
                stop_limit = STOP2_TICKS;
            end
        end
    end

    assign cur_limit    = (state_reg == ST_STOP) ? stop_limit : BIT_TICKS;
    assign tick_last    = baud_tick && (tick_cnt_reg == (cur_limit - 7'd1));
    assign last_bit_idx = {1'b0, lcr_latched_reg[1:0]} + 3'd4;

    // Stick parity sends ~EPS; otherwise EPS=1 gives even, EPS=0 odd parity.
    assign parity_bit = lcr_latched_reg[5] ? ~lcr_latched_reg[4]
                      : (lcr_latched_reg[4] ? data_xor_reg : ~data_xor_reg);

    // Next-state and next-line decode for the frame sequencer.
    always_comb begin
        state_next       = state_reg;
        tick_cnt_next    = tick_cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        lcr_latched_next = lcr_latched_reg;
        data_xor_next    = data_xor_reg;
        line_next        = line_reg;
        pop_now          = 1'b0;
        frame_end        = 1'b0;

        // Ticks only count once the frame is under way.
        if (state_reg != ST_IDLE && baud_tick) begin
            tick_cnt_next = tick_cnt_reg + 7'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                line_next = 1'b1;
                if (start_ok) begin
                    pop_now          = 1'b1;
                    shift_next       = fifo_data;
                    lcr_latched_next = lcr[5:0];
                    data_xor_next    = ^(fifo_data & word_mask);
                    tick_cnt_next    = 7'd0;
                    bit_cnt_next     = 3'd0;
                    state_next       = ST_START;
                    line_next        = 1'b0;
                end
            end
            ST_START: begin
                if (tick_last) begin
                    tick_cnt_next = 7'd0;
                    state_next    = ST_DATA;
                    line_next     = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (tick_last) begin
                    tick_cnt_next = 7'd0;
                    shift_next    = {1'b0, shift_reg[7:1]};
                    if (bit_cnt_reg == last_bit_idx) begin
                        bit_cnt_next = 3'd0;
                        if (lcr_latched_reg[3]) begin
                            state_next = ST_PARITY;
                            line_next  = parity_bit;
                        end else begin
                            state_next = ST_STOP;
                            line_next  = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        line_next    = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick_last) begin
                    tick_cnt_next = 7'd0;
                    state_next    = ST_STOP;
                    line_next     = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick_last) begin
                    tick_cnt_next = 7'd0;
                    state_next    = ST_IDLE;
                    line_next     = 1'b1;
                    frame_end     = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                line_next  = 1'b1;
            end
        endcase
    end

    // Frame sequencer registers; the line output applies the live break bit.
    always_ff @(posedge clock or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg       <= ST_IDLE;
            tick_cnt_reg    <= 7'd0;
            bit_cnt_reg     <= 3'd0;
            shift_reg       <= 8'd0;
            lcr_latched_reg <= 6'd0;
            data_xor_reg    <= 1'b0;
            line_reg        <= 1'b1;
            txd_reg         <= 1'b1;
        end else begin
            state_reg       <= state_next;
            tick_cnt_reg    <= tick_cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            lcr_latched_reg <= lcr_latched_next;
            data_xor_reg    <= data_xor_next;
            line_reg        <= line_next;
            txd_reg         <= lcr[6] ? 1'b0 : line_next;
        end
    end

    // The pop strobe is gated by reset so nothing is consumed while held.
    assign fifo_rd = pop_now & PRESETn;
    assign tx_done = frame_end;
    assign tx_busy = (state_reg != ST_IDLE);
    assign TXD     = txd_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a TX FIFO model and a
// frame scoreboard: expected line bits are queued when a word is pushed and
// compared tick by tick as the serializer emits them.
module tb_uart_tx_serializer;

    localparam int OS       = 16;
    localparam int TICK_DIV = 3;

    logic       clock      = 1'b0;
    logic       PRESETn    = 1'b1;
    logic       baud_tick  = 1'b0;
    logic [7:0] lcr        = 8'h03;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       cts_en     = 1'b0;
    logic       nCTS       = 1'b0;
    logic       fifo_rd;
    logic       TXD;
    logic       tx_busy;
    logic       tx_done;

    int n_checks = 0;
    int n_errors = 0;
    int rd_count = 0;

    typedef struct {
        logic val;
        int   ticks;
        bit   last;
    } exp_t;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .clock      (clock),
        .PRESETn    (PRESETn),
        .baud_tick  (baud_tick),
        .lcr        (lcr),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .cts_en     (cts_en),
        .nCTS       (nCTS),
        .TXD        (TXD),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clock = ~clock;

    // Baud tick: one pulse every TICK_DIV clocks.
    initial begin : tick_gen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clock);
            #1;
            baud_tick = (cnt == TICK_DIV - 1);
            cnt = (cnt + 1) % TICK_DIV;
        end
    end

    // Show-ahead FIFO model: pop when fifo_rd was high before the edge.
    initial begin : fifo_model
        logic pop_req;
        forever begin
            @(negedge clock);
            pop_req = fifo_rd;
            @(posedge clock);
            #1;
            if (pop_req === 1'b1) begin
                rd_count++;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
            fifo_empty = (fifo_q.size() == 0);
            fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected line for one frame, built from the line-control definition.
    function automatic void push_frame(input logic [7:0] lcr_v, input logic [7:0] data, input bit to_fifo);
        int   wl;
        int   stop_t;
        logic x;
        logic p;
        wl = 5 + int'(lcr_v[1:0]);
        x  = 1'b0;
        exp_q.push_back('{val: 1'b0, ticks: OS, last: 1'b0});
        for (int i = 0; i < wl; i++) begin
            exp_q.push_back('{val: data[i], ticks: OS, last: 1'b0});
            x = x ^ data[i];
        end
        if (lcr_v[3]) begin
            p = lcr_v[5] ? ~lcr_v[4] : (lcr_v[4] ? x : ~x);
            exp_q.push_back('{val: p, ticks: OS, last: 1'b0});
        end
        if (!lcr_v[2])    stop_t = OS;
        else if (wl == 5) stop_t = (3 * OS) / 2;
        else              stop_t = 2 * OS;
        exp_q.push_back('{val: 1'b1, ticks: stop_t, last: 1'b1});
        if (to_fifo) fifo_q.push_back(data);
    endfunction

    task automatic flush_frame();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.last) break;
        end
    endtask

    // Advance to the negedge of the next cycle carrying a baud tick.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 4 * TICK_DIV; c++) begin
            @(negedge clock);
            if (baud_tick) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Compare one whole frame against the scoreboard. at_rd: caller is
    // already at the negedge of the pop cycle. hook_item: item index at
    // whose start lcr/nCTS are changed (-1 for none).
    task automatic check_frame(input string tag, input bit at_rd, input int hook_item,
                               input logic [7:0] hook_lcr, input logic hook_ncts,
                               input bit expect_next_rd);
        int   rd_start;
        int   idx;
        bit   ok;
        exp_t e;
        rd_start = rd_count;
        if (!at_rd) begin
            @(negedge clock);
            for (int c = 0; c < 3000 && fifo_rd !== 1'b1; c++) @(negedge clock);
        end
        chk({tag, " fifo_rd"}, 32'(fifo_rd), 32'd1);
        if (fifo_rd !== 1'b1) begin
            flush_frame();
            return;
        end
        idx = 0;
        do begin
            e = exp_q.pop_front();
            if (idx == hook_item) begin
                lcr  = hook_lcr;
                nCTS = hook_ncts;
            end
            for (int k = 0; k < e.ticks; k++) begin
                wait_tick(ok);
                if (!ok) begin
                    chk({tag, " tick_timeout"}, 32'd0, 32'd1);
                    if (!e.last) flush_frame();
                    return;
                end
                chk($sformatf("%s bit%0d TXD", tag, idx), 32'(TXD), 32'(e.val));
                chk($sformatf("%s bit%0d tx_done", tag, idx), 32'(tx_done),
                    32'(e.last && (k == e.ticks - 1)));
            end
            idx++;
        end while (!e.last);
        chk({tag, " busy_at_done"}, 32'(tx_busy), 32'd1);
        chk({tag, " rd_pulses"}, 32'(rd_count - rd_start), 32'd1);
        @(negedge clock);
        chk({tag, " busy_after"}, 32'(tx_busy), 32'd0);
        chk({tag, " done_after"}, 32'(tx_done), 32'd0);
        chk({tag, " next_rd"}, 32'(fifo_rd), 32'(expect_next_rd));
        $display("frame %s: %0d line items compared", tag, idx);
    endtask

    initial begin : stimulus
        bit ok;
        bit line_high;
        bit no_rd;
        int rd_before;

        // Reset with a word already waiting: nothing may be popped.
        #2;
        PRESETn = 1'b0;
        push_frame(8'h03, 8'h55, 1'b1);
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("rst TXD", 32'(TXD), 32'd1);
        chk("rst tx_busy", 32'(tx_busy), 32'd0);
        chk("rst tx_done", 32'(tx_done), 32'd0);
        chk("rst fifo_rd", 32'(fifo_rd), 32'd0);
        @(posedge clock);
        #1;
        PRESETn = 1'b1;
        check_frame("8N1_55", 1'b0, -1, 8'h03, 1'b0, 1'b0);

        // 7E1; lcr rewritten mid-data must not change the frame.
        lcr = 8'h1A;
        push_frame(8'h1A, 8'h41, 1'b1);
        check_frame("7E1_41", 1'b0, 4, 8'h03, 1'b0, 1'b0);

        lcr = 8'h0A;
        push_frame(8'h0A, 8'h41, 1'b1);
        check_frame("7O1_41", 1'b0, -1, 8'h0A, 1'b0, 1'b0);

        lcr = 8'h04;
        push_frame(8'h04, 8'h1F, 1'b1);
        check_frame("5N1p5_1F", 1'b0, -1, 8'h04, 1'b0, 1'b0);

        // 8 bits, stick parity (EPS=0 -> 1), two stop bits.
        lcr = 8'h2F;
        push_frame(8'h2F, 8'h81, 1'b1);
        check_frame("8M2_81", 1'b0, -1, 8'h2F, 1'b0, 1'b0);

        // Back-to-back words.
        lcr = 8'h03;
        push_frame(8'h03, 8'hA5, 1'b1);
        push_frame(8'h03, 8'h3C, 1'b1);
        check_frame("b2b_A5", 1'b0, -1, 8'h03, 1'b0, 1'b1);
        check_frame("b2b_3C", 1'b1, -1, 8'h03, 1'b0, 1'b0);

        // Flow control: held off while nCTS=1, frame completes despite nCTS rising.
        cts_en = 1'b1;
        nCTS   = 1'b1;
        rd_before = rd_count;
        push_frame(8'h03, 8'hC3, 1'b1);
        line_high = 1'b1;
        no_rd     = 1'b1;
        repeat (60) begin
            @(negedge clock);
            line_high &= (TXD === 1'b1);
            no_rd     &= (fifo_rd === 1'b0);
        end
        chk("cts hold TXD", 32'(line_high), 32'd1);
        chk("cts hold no_rd", 32'(no_rd), 32'd1);
        chk("cts hold rd_count", 32'(rd_count - rd_before), 32'd0);
        @(posedge clock);
        #1;
        nCTS = 1'b0;
        @(negedge clock);
        check_frame("cts_C3", 1'b1, 3, 8'h03, 1'b1, 1'b0);
        nCTS   = 1'b0;
        cts_en = 1'b0;

        // Break in idle, then a frame started under break.
        @(posedge clock);
        #1;
        lcr = 8'h43;
        @(posedge clock);
        #1;
        chk("break idle TXD", 32'(TXD), 32'd0);
        lcr = 8'h03;
        @(posedge clock);
        #1;
        chk("break release TXD", 32'(TXD), 32'd1);
        lcr = 8'h43;
        fifo_q.push_back(8'h0F);
        @(negedge clock);
        for (int c = 0; c < 100 && fifo_rd !== 1'b1; c++) @(negedge clock);
        chk("break frame fifo_rd", 32'(fifo_rd), 32'd1);
        for (int t = 0; t < 20; t++) wait_tick(ok);
        chk("break mid TXD", 32'(TXD), 32'd0);
        chk("break mid busy", 32'(tx_busy), 32'd1);
        lcr = 8'h03;
        @(posedge clock);
        #1;
        chk("break end TXD shows bit0", 32'(TXD), 32'd1);
        for (int c = 0; c < 2000 && tx_done !== 1'b1; c++) @(negedge clock);
        chk("break frame tx_done", 32'(tx_done), 32'd1);
        $display("frame break_0F: checked");

        // Reset during data bit 3, then the next word goes out whole.
        fifo_q.push_back(8'h96);
        push_frame(8'h03, 8'h5A, 1'b1);
        @(negedge clock);
        for (int c = 0; c < 100 && fifo_rd !== 1'b1; c++) @(negedge clock);
        chk("midrst fifo_rd", 32'(fifo_rd), 32'd1);
        for (int t = 0; t < OS + 3 * OS + 5; t++) wait_tick(ok);
        chk("midrst pre TXD bit3", 32'(TXD), 32'd0);
        @(posedge clock);
        #3;
        PRESETn = 1'b0;
        #1;
        chk("midrst TXD", 32'(TXD), 32'd1);
        chk("midrst tx_busy", 32'(tx_busy), 32'd0);
        chk("midrst fifo_rd", 32'(fifo_rd), 32'd0);
        chk("midrst tx_done", 32'(tx_done), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        PRESETn = 1'b1;
        check_frame("midrst_5A", 1'b0, -1, 8'h03, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter OVERSAMPLE, default 16: baud_tick pulses per serial bit; legal values are even numbers from 8 to 32.
REQ-002 Port clock, input, 1: system clock; all state updates on its rising edge.
REQ-003 Port PRESETn, input, 1: reset, asynchronous, active-low.
REQ-004 Port baud_tick, input, 1: single-cycle enable pulse from the baud generator, OVERSAMPLE per bit period.
REQ-005 Port lcr, input, 8: line control. [1:0] word length (00=5 … 11=8 bits); [2] extra stop; [3] PEN; [4] EPS; [5] stick parity; [6] break.
REQ-006 Port fifo_empty, input, 1: TX FIFO holds no data.
REQ-007 Port fifo_data, input, 8: TX FIFO head word, show-ahead (valid while fifo_empty=0).
REQ-008 Port fifo_rd, output, 1: one-cycle pop strobe to the TX FIFO.
REQ-009 Port cts_en, input, 1: enable for hardware flow control.
REQ-010 Port nCTS, input, 1: clear-to-send, active-low, already synchronised.
REQ-011 Port TXD, output, 1: serial output, idle high.
REQ-012 Port tx_busy, output, 1: high in every state except IDLE.
REQ-013 Port tx_done, output, 1: one-cycle pulse on the cycle the FSM leaves STOP.

Function
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP. Encoding is free.
REQ-015 Frame start condition: in IDLE, fifo_empty=0 and (cts_en=0 or nCTS=0).
  - On that cycle: fifo_rd=1 for exactly one cycle.
  - fifo_data is latched into a shift register.
  - lcr is latched; mid-frame lcr changes do not affect the current frame.
  - Tick counter and bit counter clear to 0; next state START.
REQ-016 TXD is registered. It goes low on the clock edge that enters START (one cycle after the fifo_rd cycle).
REQ-017 Each START, DATA and PARITY bit lasts exactly OVERSAMPLE baud_tick pulses.
  - The bit advances on the cycle that carries the OVERSAMPLE-th tick.
  - Cycles without baud_tick do not advance the counter.
REQ-018 DATA sends LSB first: 5+lcr[1:0] bits, then goes to PARITY if latched PEN=1, otherwise to STOP.
REQ-019 Parity bit value:
  - PEN=1, stick=0: EPS=1 gives even parity; EPS=0 gives odd parity (over data bits only).
  - Stick=1: parity bit = ~EPS.
REQ-020 STOP holds TXD=1 for a length set by the latched lcr:
  - OVERSAMPLE ticks when [2]=0.
  - 2*OVERSAMPLE ticks when [2]=1 and word length is 6-8.
  - 3*OVERSAMPLE/2 ticks when [2]=1 and word length is 5.
REQ-021 On STOP completion: assert tx_done and return to IDLE. A new frame may start on the next cycle, so the minimum inter-frame gap is one clock plus tick alignment.
REQ-022 nCTS and fifo_empty are evaluated only in IDLE. Deasserting CTS mid-frame never truncates the frame.
REQ-023 Break: live lcr[6]=1 forces TXD=0 in every state, including IDLE.
  - The FSM keeps running and frames are not held off.
  - When lcr[6] returns to 0, TXD shows the current FSM bit on the next cycle.
REQ-024 baud_tick coincident with the frame start cycle is not counted. Counting begins in START.
REQ-025 Pop attempts while fifo_empty=1 never occur: fifo_rd is gated by REQ-015.

Reset
REQ-026 PRESETn=0 asynchronously forces the following, including mid-frame with no partial completion:
  - state=IDLE; TXD=1; fifo_rd=0; tx_busy=0; tx_done=0.
  - Tick counter, bit counter, shift register and latched lcr all cleared to 0.
REQ-027 After PRESETn rises, the first pop occurs no earlier than the first rising clock edge that satisfies REQ-015.

Verification
REQ-028 8N1, OVERSAMPLE=16, lcr=0x03, FIFO holds 0x55.
  - fifo_rd pulses once.
  - TXD = 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks, 160 ticks total.
  - tx_done pulses once; tx_busy falls with it.
REQ-029 7E1, lcr=0x1A, data 0x41.
  - Data bits 1,0,0,0,0,0,1; parity 0; one stop bit; 10 bits total.
  - With lcr=0x0A (odd parity) the parity bit is 1.
REQ-030 5-bit, 1.5 stop, lcr=0x04, data 0x1F.
  - Start, five 1s, then stop high for 24 ticks; tx_done is asserted 24 ticks into STOP.
REQ-031 Flow control: cts_en=1, nCTS=1, FIFO non-empty.
  - No fifo_rd, TXD stays 1.
  - After nCTS falls, the frame starts one cycle later.
  - Raising nCTS mid-DATA does not cut the frame.
REQ-032 Back-to-back: FIFO holds 0xA5 then 0x3C.
  - Two fifo_rd pulses; the second occurs one cycle after the first tx_done.
  - TXD stays high between frames only for the stop bit plus that gap.
REQ-033 Reset mid-DATA (bit 3): PRESETn low, asynchronously.
  - TXD=1, tx_busy=0 immediately.
  - After release, the next FIFO word is sent as a complete frame.
